// File: rtl/booth_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default operand width and the special-case result constants.
package booth_divider_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CALC   = 3'd3,
    ST_FIX    = 3'd4
  } state_t;

  // Quotient returned for a zero divisor, and the most-negative operand.
  localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;
  localparam logic [WIDTH_DEF-1:0] MOST_NEG  = {1'b1, {(WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/booth_divider_ctrl.sv
// Control path of the divider: operation sequencing FSM, iteration counter,
// datapath strobes and the registered busy/done outputs.
module booth_divider_ctrl
  import booth_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic divisor_zero,
  output logic load_a,
  output logic load_b,
  output logic shift_sub,
  output logic fix,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t        state;
  logic [CW-1:0] count;

  // Sequence IDLE -> LOAD_A -> LOAD_B -> CALC x WIDTH -> FIX -> IDLE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD_A;
            busy  <= 1'b1;
          end
        end
        ST_LOAD_A: state <= ST_LOAD_B;
        ST_LOAD_B: begin
          if (divisor_zero) begin
            state <= ST_FIX;
          end else begin
            count <= CW'(WIDTH);
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          count <= count - 1'b1;
          if (count == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign load_a    = (state == ST_LOAD_A);
  assign load_b    = (state == ST_LOAD_B);
  assign shift_sub = (state == ST_CALC);
  assign fix       = (state == ST_FIX);

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider, radix-2 restoring, truncating toward zero.
// Operands arrive serially on data_in; result is {remainder, quotient}.
module booth_divider
  import booth_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               div_zero,
  output logic               ovf
);

  localparam logic [WIDTH-1:0] QUOT_DIV0   = {WIDTH{DIV0_QUOT[0]}};
  localparam logic [WIDTH-1:0] MOST_NEG_W  = {MOST_NEG[WIDTH_DEF-1], {(WIDTH-1){1'b0}}};

  logic load_a, load_b, shift_sub, fix;

  logic [WIDTH-1:0] dividend;
  logic             sign_b;
  logic [WIDTH:0]   mag_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic             sign_a;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH:0]   mag_in;
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;

  booth_divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .divisor_zero (data_in == '0),
    .load_a       (load_a),
    .load_b       (load_b),
    .shift_sub    (shift_sub),
    .fix          (fix),
    .busy         (busy),
    .done         (done)
  );

  // Operand magnitudes, one restoring step, and the final sign fix-up.
  // NOTE: every signal gets a value on every path, so no latch is inferred.
  always_comb begin
    sign_a     = dividend[WIDTH-1];
    mag_a      = sign_a ? (~dividend + 1'b1) : dividend;
    mag_in     = data_in[WIDTH-1] ? (~{1'b1, data_in} + 1'b1) : {1'b0, data_in};
    rem_sh     = {rem, quo[WIDTH-1]};
    fits       = (rem_sh >= mag_b);
    rem_next   = WIDTH'(fits ? (rem_sh - mag_b) : rem_sh);
    quo_signed = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
    rem_signed = sign_a ? (~rem + 1'b1) : rem;
  end

  // Datapath working registers; only meaningful between LOAD_A and FIX.
  // NOTE: these carry no reset because each operation fully reloads them
  // before use; only the architecturally visible outputs are reset.
  always_ff @(posedge clk) begin
    if (load_a) dividend <= data_in;
    if (load_b) begin
      sign_b <= data_in[WIDTH-1];
      mag_b  <= mag_in;
      rem    <= '0;
      quo    <= mag_a;
    end else if (shift_sub) begin
      rem <= rem_next;
      quo <= {quo[WIDTH-2:0], fits};
    end
  end

  // Visible outputs: flags refreshed at LOAD_B, result written at FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (load_b) begin
        div_zero <= (data_in == '0);
        ovf      <= (dividend == MOST_NEG_W) && (data_in == '1);
      end
      if (fix) begin
        result <= div_zero ? {dividend, QUOT_DIV0} : {rem_signed, quo_signed};
      end
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Randomized self-checking bench for booth_divider against an arithmetic
// reference using the language's own truncating / and % operators.
module tb_booth_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [31:0] result;
  logic        done, busy, div_zero, ovf;

  int vectors = 0;
  int miscompares = 0;

  booth_divider #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: signed division truncating toward zero, with the
  // divide-by-zero and most-negative / -1 special cases.
  function automatic logic [31:0] model(input logic signed [15:0] a, input logic signed [15:0] b);
    int ai, bi, q, r;
    ai = a;
    bi = b;
    if (bi == 0) return {a, 16'hFFFF};
    if (ai == -32768 && bi == -1) return {16'h0000, 16'h8000};
    q = ai / bi;
    r = ai % bi;
    return {r[15:0], q[15:0]};
  endfunction

  // One operation. Called just after a rising edge (+#1) with the DUT idle.
  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input bit hold, input bit toggle);
    int n;
    logic [31:0] exp;
    int lat;
    exp = model(a, b);
    lat = (b == 16'h0) ? 3 : 19;
    start = 1'b1;
    @(posedge clk); #1;                 // edge E
    n = 0;
    data_in = a;
    if (!hold) start = 1'b0;
    @(posedge clk); #1; n++;            // LOAD_A
    data_in = b;
    @(posedge clk); #1; n++;            // LOAD_B
    data_in = 16'h0;
    while (!done && n < 60) begin
      @(posedge clk); #1; n++;
      if (toggle && n >= 3 && n <= 16) begin
        start   = 1'($urandom);
        data_in = 16'($urandom);
        if (n == 10) check("busy_in_calc", {31'b0, busy}, 32'd1);
      end
      if (toggle && n == 17) start = hold;
    end
    check("latency", n, lat);
    check("result", result, exp);
    check("div_zero", {31'b0, div_zero}, {31'b0, (b == 16'h0)});
    check("ovf", {31'b0, ovf}, {31'b0, (a == 16'h8000 && b == 16'hFFFF)});
    check("busy_at_done", {31'b0, busy}, 32'd0);
    if (!hold) begin
      @(posedge clk); #1;
      check("done_pulse", {31'b0, done}, 32'd0);
      check("result_hold", result, exp);
      check("div_zero_hold", {31'b0, div_zero}, {31'b0, (b == 16'h0)});
    end
  endtask

  initial begin
    bit seen_done;
    logic [15:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    data_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_flags", {28'b0, done, busy, div_zero, ovf}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    op(16'd100, 16'd7, 1'b0, 1'b0);
    check("tp_100_7", result, 32'h0002_000E);
    op(-16'sd100, 16'd7, 1'b0, 1'b0);
    check("tp_m100_7", result, 32'hFFFE_FFF2);
    op(16'd100, -16'sd7, 1'b0, 1'b0);
    check("tp_100_m7", result, 32'h0002_FFF2);
    op(16'd13, 16'd0, 1'b0, 1'b0);
    check("tp_div0", result, 32'h000D_FFFF);
    op(16'h8000, 16'hFFFF, 1'b1, 1'b0);
    check("tp_ovf", result, 32'h0000_8000);
    op(16'd30007, 16'd720, 1'b0, 1'b0);
    check("tp_b2b", result, 32'h01E7_0029);
    op(16'd1234, -16'sd56, 1'b0, 1'b1);

    // Abort in the middle of CALC; no done may follow.
    op(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_in = 16'd500;
    @(posedge clk); #1;
    data_in = 16'd3;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_result", result, 32'h0);
    check("abort_flags", {28'b0, done, busy, div_zero, ovf}, 32'h0);
    seen_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_quiet", {31'b0, seen_done}, 32'd0);
    op(16'd1200, 16'd140, 1'b0, 1'b0);
    check("tp_after_abort", result, 32'h0050_0008);

    // Random operations with occasional zero divisors, overflow, b2b, noise.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0;
        1: rb = 16'($urandom_range(1, 9));
        2: begin ra = 16'h8000; rb = 16'hFFFF; end
        3: ra = 16'h8000;
        default: ;
      endcase
      op(ra, rb, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider, split into a datapath and a control path; the inverse operation of the team's booth multiplier.
- Loads dividend and divisor serially over one shared data_in bus, then runs a radix-2 restoring division for WIDTH cycles.
- Returns quotient and remainder packed into one 2*WIDTH result word, in the same bus style as the multiplier.
- Sits beside the multiplier in the arithmetic unit and is driven by the same start/data_in sequencer.

Parameters:
- WIDTH, 16, operand width; also the number of iteration cycles. Quotient and remainder are WIDTH bits each.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  sampled in IDLE; starts an operation
- data_in  input  WIDTH  signed two's-complement operand bus; dividend first cycle, divisor second cycle
- result  output  2*WIDTH  {remainder, quotient}
- done  output  1  one-cycle pulse when result updates
- busy  output  1  high from LOAD_A through FIX
- div_zero  output  1  sticky per-operation flag: divisor was 0
- ovf  output  1  sticky per-operation flag: most-negative dividend divided by -1

Behaviour:
- Reset, sampled at a rising edge when rst=1:
  - state goes to IDLE, iteration counter to 0.
  - result, done, busy, div_zero and ovf all go to 0.
  - Reset overrides everything, including mid-operation; the aborted operation produces no done.
- States: IDLE, LOAD_A, LOAD_B, CALC, FIX.
- IDLE:
  - start=1 at edge E moves to LOAD_A.
  - start=0 stays in IDLE.
- LOAD_A: at edge E+1, capture data_in as the dividend, then go to LOAD_B.
- LOAD_B: at edge E+2, capture data_in as the divisor.
  - Record both sign bits and convert both operands to magnitudes (WIDTH+1 bits internally, so that -2^(WIDTH-1) is representable).
  - Clear div_zero and ovf.
  - Divisor==0: set div_zero and go straight to FIX.
  - Otherwise load the counter with WIDTH and go to CALC.
- CALC, one iteration per edge, WIDTH edges (E+3 .. E+2+WIDTH):
  - Shift the {partial remainder, quotient} register left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore the partial remainder and set the LSB to 0.
  - Decrement the counter; at 0, go to FIX.
- FIX, edge E+3+WIDTH (E+3 when divisor is zero):
  - Quotient is negated if the two operand signs differ.
  - Remainder takes the dividend's sign, i.e. truncation toward zero, matching Verilog / and %.
  - Write result; done=1 during the following cycle; go to IDLE.
- Latency: 19 cycles from the start edge to done for WIDTH=16; 3 cycles for divide-by-zero.
- Divide by zero: quotient is all ones, remainder is the dividend unchanged, div_zero=1.
- Overflow (dividend = -2^(WIDTH-1), divisor = -1):
  - Quotient wraps to -2^(WIDTH-1) (16'h8000), remainder 0, ovf=1.
  - The operation runs the normal CALC path; ovf is detected in LOAD_B.
- result, div_zero and ovf hold their values until the next FIX or reset.
- start is ignored outside IDLE.
- If start is still high in the IDLE cycle right after done, a new operation begins back-to-back, with no dead cycles beyond that IDLE cycle.
- data_in is only sampled in LOAD_A and LOAD_B.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, CALC, FIX) and its encoding;
  - WIDTH default;
  - localparams for the divide-by-zero quotient (all ones) and the most-negative value.
- One sub-module, booth_divider_ctrl: the FSM and iteration counter.
  - Emits load_a, load_b, shift_sub and fix strobes, plus busy and done.
  - The top level holds the datapath registers, the subtractor and the sign fix-up.

Test Plan:
- rst pulse, then start=1, data_in 100 then 7 -> done 19 cycles after start, result=32'h0002_000E, div_zero=0, ovf=0.
- Operands -100, 7 -> result=32'hFFFE_FFF2 (remainder -2, quotient -14). Operands 100, -7 -> result=32'h0002_FFF2.
- Operands 13, 0 -> done 3 cycles after start, result=32'h000D_FFFF, div_zero=1.
- Operands -32768, -1 -> result=32'h0000_8000, ovf=1. Next operation 30007, 720 -> result=32'h01E7_0029 with ovf cleared; start held high throughout, so the second operation is back-to-back.
- Assert rst mid-CALC (cycle 8) -> next cycle state IDLE, result=0, busy=0, and no done. A fresh operation 1200, 140 then gives 32'h0050_0008.
- Toggle start and data_in while in CALC -> ignored; result is unaffected; busy stays high until FIX.
